// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: frame-granular round-robin arbiter sharing one FFT between two channels.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req0_*/req1_*               sample streams from channel 0/1 (msg/val in, rdy out)
//   fft_in_*                    sample stream to the FFT (msg/val out, rdy in)
//   fft_out_*                   result stream from the FFT (msg/val in, rdy out)
//   resp0_*/resp1_*             result streams to channel 0/1 (msg/val out, rdy in)
//   owner, busy                 granted channel, high while a frame is in flight
//   frames0/frames1             completed-frame counters, built only with FFT_FRAME_ARB_STATS_EN
module fft_frame_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,
    input  logic [BIT_WIDTH-1:0] req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,
    output logic [BIT_WIDTH-1:0] fft_in_msg,
    output logic                 fft_in_val,
    input  logic                 fft_in_rdy,
    input  logic [BIT_WIDTH-1:0] fft_out_msg,
    input  logic                 fft_out_val,
    output logic                 fft_out_rdy,
    output logic [BIT_WIDTH-1:0] resp0_msg,
    output logic                 resp0_val,
    input  logic                 resp0_rdy,
    output logic [BIT_WIDTH-1:0] resp1_msg,
    output logic                 resp1_val,
    input  logic                 resp1_rdy,
    output logic                 owner,
    output logic                 busy,
    output logic [15:0]          frames0,
    output logic [15:0]          frames1
);
    localparam int CW = $clog2(N_SAMPLES);
    localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t          state, state_n;
    logic            owner_n, last_grant, last_grant_n;
    logic [CW-1:0]   cnt, cnt_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            busy       <= state_n != IDLE;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        fft_in_msg   = owner ? req1_msg : req0_msg;
        fft_in_val   = 1'b0;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        fft_out_rdy  = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        case (state)
            IDLE: if (req0_val | req1_val) begin
                // a tie goes to the channel that did not win last time
                owner_n = (req0_val & req1_val) ? ~last_grant : req1_val;
                cnt_n   = '0;
                state_n = FEED;
            end
            FEED: begin
                fft_in_val = owner ? req1_val : req0_val;
                req0_rdy   = ~owner & fft_in_rdy;
                req1_rdy   = owner & fft_in_rdy;
                if ((owner ? req1_val : req0_val) & fft_in_rdy) begin
                    cnt_n   = cnt + 1'b1;
                    state_n = cnt == LAST ? DRAIN : FEED;
                end
            end
            DRAIN: begin
                resp0_val   = ~owner & fft_out_val;
                resp1_val   = owner & fft_out_val;
                fft_out_rdy = owner ? resp1_rdy : resp0_rdy;
                if (fft_out_val & (owner ? resp1_rdy : resp0_rdy) && cnt == LAST) begin
                    cnt_n        = '0;
                    last_grant_n = owner;
                    state_n      = IDLE;
                end else if (fft_out_val & (owner ? resp1_rdy : resp0_rdy)) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // results are broadcast; only the owner sees val
    assign resp0_msg = fft_out_msg;
    assign resp1_msg = fft_out_msg;

`ifdef FFT_FRAME_ARB_STATS_EN
    logic frame_done;

    assign frame_done = state == DRAIN && fft_out_val && fft_out_rdy && cnt == LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames0 <= '0;
            frames1 <= '0;
        end else if (frame_done) begin
            frames0 <= frames0 + 16'(~owner);
            frames1 <= frames1 + 16'(owner);
        end
    end
`else
    assign frames0 = '0;
    assign frames1 = '0;
`endif
endmodule
